// File: rtl/pixel_paint_ctrl.sv
// Byte-command pixel painter: a host sets a cursor and plots 2-bit pixels; display reads have priority.
// Optional framebuffer clear command is built when PAINT_FILL_EN is defined.
module pixel_paint_ctrl #(
    parameter int FB_W   = 160,
    parameter int FB_H   = 120,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_valid,
    input  logic [7:0]        host_data,
    output logic              host_ready,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [1:0]        disp_data,
    output logic [ADDR_W-1:0] fb_addr,
    output logic              fb_we,
    output logic [1:0]        fb_wdata,
    input  logic [1:0]        fb_rdata,
    output logic              busy
);

    localparam int XW = (FB_W > 1) ? $clog2(FB_W) : 1;
    localparam int YW = (FB_H > 1) ? $clog2(FB_H) : 1;

`ifdef PAINT_FILL_EN
    localparam int FB_SIZE = FB_W * FB_H;
    typedef enum logic [1:0] {S_OP, S_ARG, S_WRITE, S_FILL} state_t;
`else
    typedef enum logic [1:0] {S_OP, S_ARG, S_WRITE} state_t;
`endif

    typedef enum logic [7:0] {
        OP_SET_X = 8'h01,
        OP_SET_Y = 8'h02,
        OP_PIXEL = 8'h03,
        OP_FILL  = 8'h04
    } opcode_t;

    state_t            state;
    opcode_t           op_q;
    logic [XW-1:0]     x_q;
    logic [YW-1:0]     y_q;
    logic [1:0]        colour;
    logic              ready_en;
`ifdef PAINT_FILL_EN
    logic [ADDR_W-1:0] fill_cnt;
`endif

    logic              accept;
    logic              disp_sel;
    logic              writing;
    logic [ADDR_W-1:0] wr_addr;

    assign accept  = host_valid && host_ready;
    // Reset also masks the display path so fb_addr reads zero while rst_n is low.
    assign disp_sel = disp_req && rst_n;
    assign wr_addr  = ADDR_W'(int'(y_q) * FB_W + int'(x_q));

`ifdef PAINT_FILL_EN
    assign writing = !disp_sel && (state == S_WRITE || state == S_FILL);
`else
    assign writing = !disp_sel && (state == S_WRITE);
`endif

    // NOTE: pure combinational outputs assign every signal on every path, so no latch can form.
    always_comb begin
        fb_addr = '0;
        if (disp_sel) begin
            fb_addr = disp_addr;
        end else if (state == S_WRITE) begin
            fb_addr = wr_addr;
`ifdef PAINT_FILL_EN
        end else if (state == S_FILL) begin
            fb_addr = fill_cnt;
`endif
        end
    end

    assign fb_we      = writing;
    assign fb_wdata   = writing ? colour : 2'd0;
    assign host_ready = ready_en && (state == S_OP || state == S_ARG);
    assign busy       = (state != S_OP);
    assign disp_data  = disp_valid ? fb_rdata : 2'd0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_OP;
            op_q       <= OP_SET_X;
            x_q        <= '0;
            y_q        <= '0;
            colour     <= '0;
            ready_en   <= 1'b0;
            disp_valid <= 1'b0;
`ifdef PAINT_FILL_EN
            fill_cnt   <= '0;
`endif
        end else begin
            ready_en   <= 1'b1;
            disp_valid <= disp_req;
            case (state)
                S_OP: begin
                    if (accept) begin
                        case (host_data)
                            OP_SET_X, OP_SET_Y, OP_PIXEL, OP_FILL: begin
                                op_q  <= opcode_t'(host_data);
                                state <= S_ARG;
                            end
                            default: ;
                        endcase
                    end
                end
                S_ARG: begin
                    if (accept) begin
                        state <= S_OP;
                        case (op_q)
                            OP_SET_X: x_q <= (int'(host_data) > FB_W - 1) ? XW'(FB_W - 1) : XW'(host_data);
                            OP_SET_Y: y_q <= (int'(host_data) > FB_H - 1) ? YW'(FB_H - 1) : YW'(host_data);
                            OP_PIXEL: begin
                                colour <= host_data[1:0];
                                state  <= S_WRITE;
                            end
`ifdef PAINT_FILL_EN
                            OP_FILL: begin
                                colour   <= host_data[1:0];
                                fill_cnt <= '0;
                                state    <= S_FILL;
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                S_WRITE: begin
                    if (!disp_req) begin
                        state <= S_OP;
                        if (int'(x_q) == FB_W - 1) begin
                            x_q <= '0;
                            y_q <= (int'(y_q) == FB_H - 1) ? '0 : y_q + 1'b1;
                        end else begin
                            x_q <= x_q + 1'b1;
                        end
                    end
                end
`ifdef PAINT_FILL_EN
                S_FILL: begin
                    if (!disp_req) begin
                        if (fill_cnt == ADDR_W'(FB_SIZE - 1)) state <= S_OP;
                        else fill_cnt <= fill_cnt + 1'b1;
                    end
                end
`endif
                default: state <= S_OP;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_paint_ctrl.sv
// Directed bench for pixel_paint_ctrl with hand-computed expectations; FILL checks follow PAINT_FILL_EN.
module tb_pixel_paint_ctrl;

    localparam int ADDR_W = 15;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              host_valid = 1'b0;
    logic [7:0]        host_data = '0;
    logic              host_ready;
    logic              disp_req = 1'b0;
    logic [ADDR_W-1:0] disp_addr = '0;
    logic              disp_valid;
    logic [1:0]        disp_data;
    logic [ADDR_W-1:0] fb_addr;
    logic              fb_we;
    logic [1:0]        fb_wdata;
    logic [1:0]        fb_rdata = '0;
    logic              busy;

    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;
    int wr_addr = 0;
    int wr_data = 0;
    int we_in_disp = 0;

    pixel_paint_ctrl #(.FB_W(160), .FB_H(120), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_valid(disp_valid), .disp_data(disp_data),
        .fb_addr(fb_addr), .fb_we(fb_we), .fb_wdata(fb_wdata), .fb_rdata(fb_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fb_we) begin
            wr_cnt  = wr_cnt + 1;
            wr_addr = int'(fb_addr);
            wr_data = int'(fb_wdata);
            if (disp_req) we_in_disp = we_in_disp + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(posedge clk); #1;
        host_valid = 1'b1;
        host_data  = b;
        @(negedge clk);
        while (!host_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("byte_accept", host_ready, 1);
        @(posedge clk); #1;
        host_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic pixel(input string tag, input logic [7:0] c, input int exp_addr);
        int base;
        base = wr_cnt;
        send_byte(8'h03);
        send_byte(c);
        settle();
        check({tag, "_count"}, wr_cnt - base, 1);
        check({tag, "_addr"}, wr_addr, exp_addr);
        check({tag, "_data"}, wr_data, int'(c[1:0]));
    endtask

    initial begin
        int base;
        int n;
        int hr_high;
        int we_high;

        // Reset values while rst_n is low
        repeat (3) @(negedge clk);
        check("rst_host_ready", host_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_fb_we", fb_we, 0);
        check("rst_fb_addr", fb_addr, 0);
        check("rst_fb_wdata", fb_wdata, 0);
        check("rst_disp_valid", disp_valid, 0);
        check("rst_disp_data", disp_data, 0);
        rst_n = 1'b1;
        #1 check("ready_before_clock", host_ready, 0);
        @(posedge clk);
        @(negedge clk);
        check("ready_after_release", host_ready, 1);

        // x=5 y=3 colour 2 -> 485, then cursor at x=6
        send_byte(8'h01); send_byte(8'h05);
        send_byte(8'h02); send_byte(8'h03);
        pixel("pix485", 8'h02, 485);
        pixel("pix486", 8'h00, 486);

        // Clamped corner then wrap to origin
        send_byte(8'h01); send_byte(8'hFF);
        send_byte(8'h02); send_byte(8'hFF);
        pixel("pix_corner", 8'h01, 19199);
        pixel("pix_wrap", 8'h03, 0);

        // Pending write stalled behind display traffic
        send_byte(8'h01); send_byte(8'h0A);
        send_byte(8'h02); send_byte(8'h00);
        @(posedge clk); #1;
        disp_req = 1'b1;
        disp_addr = 15'd7;
        base = wr_cnt;
        send_byte(8'h03); send_byte(8'h01);
        hr_high = 0;
        we_high = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (host_ready) hr_high++;
            if (fb_we) we_high++;
        end
        check("stall_ready_low", hr_high, 0);
        check("stall_no_we", we_high, 0);
        check("stall_busy", busy, 1);
        @(posedge clk); #1;
        disp_req = 1'b0;
        @(negedge clk);
        check("stall_release_we", fb_we, 1);
        check("stall_release_addr", fb_addr, 10);
        check("stall_release_data", fb_wdata, 1);
        settle();
        check("stall_write_count", wr_cnt - base, 1);
        check("we_during_disp", we_in_disp, 0);

        // Display read path: valid and data one cycle after request
        @(posedge clk); #1;
        disp_req = 1'b1;
        disp_addr = 15'd100;
        @(negedge clk);
        check("disp_fb_addr", fb_addr, 100);
        check("disp_fb_we", fb_we, 0);
        @(posedge clk); #1;
        disp_req = 1'b0;
        fb_rdata = 2'd3;
        @(negedge clk);
        check("disp_valid", disp_valid, 1);
        check("disp_data", disp_data, 3);
        @(posedge clk); #1;
        fb_rdata = 2'd0;
        @(negedge clk);
        check("disp_valid_drop", disp_valid, 0);

        // Unknown opcode is dropped, so 03 01 that follows is a full PIXEL
        send_byte(8'h07);
        pixel("pix_after_bad_op", 8'h01, 11);

`ifdef PAINT_FILL_EN
        send_byte(8'h04);
        send_byte(8'h01);
        base = 0;
        n = 0;
        we_high = 0;
        hr_high = 0;
        while (busy && n < 25000) begin
            @(negedge clk);
            if (fb_we) begin
                if (int'(fb_addr) != base) we_high++;
                if (fb_wdata != 2'd1) we_high++;
                base++;
            end
            n++;
        end
        check("fill_done", busy, 0);
        check("fill_writes", base, 19200);
        check("fill_order_errors", we_high, 0);
        pixel("pix_after_fill", 8'h02, 12);

        // Reset mid-fill at address 500
        send_byte(8'h04);
        send_byte(8'h02);
        n = 0;
        @(negedge clk);
        while (!(fb_we && fb_addr == 15'd500) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("fill_reached_500", fb_addr, 500);
`else
        base = wr_cnt;
        send_byte(8'h04);
        send_byte(8'h01);
        repeat (20) @(posedge clk);
        #1;
        check("fill_disabled_writes", wr_cnt - base, 0);
        check("fill_disabled_busy", busy, 0);
        check("fill_disabled_ready", host_ready, 1);

        // Reset while a pixel write is pending behind display traffic
        @(posedge clk); #1;
        disp_req = 1'b1;
        send_byte(8'h03);
        send_byte(8'h02);
        @(negedge clk);
        check("pending_busy", busy, 1);
        disp_req = 1'b0;
`endif
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_fb_we", fb_we, 0);
        check("async_rst_fb_addr", fb_addr, 0);
        check("async_rst_fb_wdata", fb_wdata, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_ready", host_ready, 0);
        check("async_rst_disp_valid", disp_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        base = wr_cnt;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("no_write_after_reset", wr_cnt - base, 0);
        check("ready_after_reset", host_ready, 1);
        pixel("pix_after_reset", 8'h02, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pixel_paint_ctrl.md
PIXEL_PAINT_CTRL -- requirements
Module: pixel_paint_ctrl

Interface
REQ-001 SHALL have parameter FB_W, default 160, framebuffer width in pixels.
REQ-002 SHALL have parameter FB_H, default 120, framebuffer height in pixels.
REQ-003 SHALL have parameter ADDR_W, default 15, framebuffer address width; must satisfy 2^ADDR_W >= FB_W*FB_H.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port host_valid  input  1  host command byte valid.
REQ-007 SHALL have port host_data  input  8  host command byte.
REQ-008 SHALL have port host_ready  output  1  byte accepted on a cycle with host_valid && host_ready.
REQ-009 SHALL have port disp_req  input  1  display read request.
REQ-010 SHALL have port disp_addr  input  ADDR_W  display read address.
REQ-011 SHALL have port disp_valid  output  1  disp_data valid.
REQ-012 SHALL have port disp_data  output  2  pixel colour returned to display.
REQ-013 SHALL have port fb_addr  output  ADDR_W  framebuffer address.
REQ-014 SHALL have port fb_we  output  1  framebuffer write enable.
REQ-015 SHALL have port fb_wdata  output  2  framebuffer write data.
REQ-016 SHALL have port fb_rdata  input  2  framebuffer read data, valid one cycle after a non-write address.
REQ-017 SHALL have port busy  output  1  high whenever FSM is not in S_OP.

Function
REQ-018 SHALL implement FSM states S_OP (await opcode), S_ARG (await payload byte), S_WRITE (single pixel pending), S_FILL (clearing framebuffer).
REQ-019 SHALL assert host_ready only in S_OP and S_ARG.
REQ-020 SHALL decode opcodes in S_OP: 0x01 SET_X, 0x02 SET_Y, 0x03 PIXEL, 0x04 FILL, each moving to S_ARG; any other opcode discarded, stay in S_OP.
REQ-021 SHALL, on SET_X/SET_Y payload, load cursor x/y with min(payload, FB_W-1)/min(payload, FB_H-1) and return to S_OP.
REQ-022 SHALL, on PIXEL payload, latch colour = payload[1:0] and enter S_WRITE.
REQ-023 SHALL compute write address as y*FB_W + x, truncated to ADDR_W.
REQ-024 SHALL give the display absolute priority: on any cycle with disp_req high, fb_addr = disp_addr, fb_we = 0, and any pending write stalls.
REQ-025 SHALL, in S_WRITE with disp_req low, drive fb_we=1 for exactly one cycle, then advance cursor and return to S_OP.
REQ-026 SHALL advance cursor as x+1; at x=FB_W-1, x wraps to 0 and y increments; at y=FB_H-1, y wraps to 0.
REQ-027 SHALL assert disp_valid exactly one cycle after each disp_req cycle, with disp_data = fb_rdata on that cycle.
REQ-028 SHALL drive fb_we=0 and fb_wdata=0 whenever not writing.

Reset
REQ-029 SHALL, while rst_n low, force state S_OP, x=0, y=0, colour=0, fill counter=0, host_ready=0, fb_we=0, fb_addr=0, fb_wdata=0, disp_valid=0, disp_data=0, busy=0.
REQ-030 SHALL, on rst_n assertion mid-write or mid-fill, abandon the operation immediately; no further fb_we after reset release without a new command.
REQ-031 SHALL assert host_ready on the first clock after rst_n deasserts.

Configuration
REQ-032 SHALL, when PAINT_FILL_EN is defined, on FILL payload latch colour and enter S_FILL, writing addresses 0 to FB_W*FB_H-1 in order, one per non-display cycle, then return to S_OP with cursor unchanged.
REQ-033 SHALL, when PAINT_FILL_EN is undefined, consume the FILL opcode and its payload byte without any framebuffer write and return to S_OP; S_FILL logic absent.

Verification
REQ-034 SHALL cover: bytes 01 05, 02 03, 03 02 with disp_req low -> one fb_we pulse, fb_addr=485, fb_wdata=2, cursor x=6 y=3.
REQ-035 SHALL cover: SET_X 0xFF, SET_Y 0xFF, PIXEL 1 -> write at 19199, cursor wraps to x=0 y=0.
REQ-036 SHALL cover: PIXEL pending with disp_req held high 10 cycles -> no fb_we during those cycles, write on first cycle disp_req low, host_ready low throughout.
REQ-037 SHALL cover: disp_req with disp_addr=100, fb_rdata=3 next cycle -> disp_valid=1, disp_data=3 one cycle after request.
REQ-038 SHALL cover: with PAINT_FILL_EN, FILL 1 and no display traffic -> exactly 19200 fb_we cycles, addresses 0..19199, busy high throughout; without macro -> zero fb_we.
REQ-039 SHALL cover: rst_n pulsed low mid-FILL at address 500 -> fb_we drops asynchronously, all outputs at reset values, no writes after release.
